// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack handshake, holds the
// instruction for decode/execute and computes the next PC when execute commits.
module fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic        instr_valid,
  input  logic        commit,
  input  logic        branch,
  input  logic        jump,
  input  logic        zero,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fault
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;
  localparam logic [1:0] S_FAULT = 2'd3;

  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]        state;
  logic [CNT_W-1:0]  wait_cnt;
  logic [31:0]       next_pc;
  logic signed [31:0] br_off;
  logic              br_taken;

  // Next-PC selection; jump outranks branch, bne is distinguished by opcode bit 0.
  always_comb begin
    pc_plus4 = pc + 32'd4;
    br_off   = $signed({{14{instr[15]}}, instr[15:0], 2'b00});
    br_taken = instr[26] ? ~zero : zero;
    next_pc  = pc_plus4;
    if (jump)
      next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
    else if (branch && br_taken)
      next_pc = pc_plus4 + $unsigned(br_off);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      pc       <= RESET_PC;
      instr    <= 32'd0;
      wait_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          state    <= S_FETCH;
          wait_cnt <= '0;
        end
        S_FETCH: begin
          if (imem_ack) begin
            instr <= imem_rdata;
            state <= S_EXEC;
          end else if (wait_cnt == CNT_LAST) begin
            state <= S_FAULT;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        S_EXEC: begin
          if (commit) begin
            pc       <= next_pc;
            state    <= S_FETCH;
            wait_cnt <= '0;
          end
        end
        S_FAULT: state <= S_FAULT;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Status outputs decode straight from state so reset clears them without waiting a clock.
  assign imem_req    = (state == S_FETCH);
  assign instr_valid = (state == S_EXEC);
  assign fault       = (state == S_FAULT);
  assign imem_addr   = pc;
  assign opcode      = instr[31:26];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: transaction tasks drive the handshake and keep a
// reference PC/instruction; a negedge process compares every output each cycle.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          TIMEOUT  = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic        instr_valid;
  logic        commit = 1'b0;
  logic        branch = 1'b0;
  logic        jump = 1'b0;
  logic        zero = 1'b0;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fault;

  fetch_unit #(.RESET_PC(RESET_PC), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .opcode(opcode), .instr_valid(instr_valid),
    .commit(commit), .branch(branch), .jump(jump), .zero(zero),
    .pc(pc), .pc_plus4(pc_plus4), .fault(fault)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  logic        check_en = 1'b0;
  logic [31:0] m_pc = RESET_PC;
  logic [31:0] m_instr = 32'd0;
  logic        exp_req = 1'b0;
  logic        exp_valid = 1'b0;
  logic        exp_fault = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference next PC from the architectural rules, in plain arithmetic.
  function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] w,
                                             input logic br, input logic jmp, input logic z);
    logic [31:0] seq;
    int          off;
    logic        taken;
    seq   = p + 32'd4;
    off   = $signed(w[15:0]) * 4;
    taken = (w[26] == 1'b0) ? z : !z;
    if (jmp) return (seq & 32'hF000_0000) | ((w & 32'h03FF_FFFF) << 2);
    if (br && taken) return seq + 32'(off);
    return seq;
  endfunction

  always @(negedge clk) begin
    if (check_en) begin
      chk("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
      chk("instr_valid", {31'd0, instr_valid}, {31'd0, exp_valid});
      chk("fault", {31'd0, fault}, {31'd0, exp_fault});
      chk("pc", pc, m_pc);
      chk("imem_addr", imem_addr, m_pc);
      chk("pc_plus4", pc_plus4, m_pc + 32'd4);
      chk("instr", instr, m_instr);
      chk("opcode", {26'd0, opcode}, m_instr >> 26);
    end
  end

  task automatic go;
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse, then the IDLE cycle, ending in the first FETCH cycle.
  task automatic apply_reset;
    reset = 1'b1; imem_ack = 1'b0; commit = 1'b0; branch = 1'b0; jump = 1'b0;
    m_pc = RESET_PC; m_instr = 32'd0;
    exp_req = 1'b0; exp_valid = 1'b0; exp_fault = 1'b0;
    #1;
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_pc", pc, RESET_PC);
    chk("rst_instr", instr, 32'd0);
    go; go;
    reset = 1'b0;
    #1;
    chk("idle_req", {31'd0, imem_req}, 32'd0);
    go;
    exp_req = 1'b1;
    chk("fetch_req", {31'd0, imem_req}, 32'd1);
    chk("fetch_addr", imem_addr, RESET_PC);
  endtask

  task automatic fetch(input logic [31:0] word, input int waits);
    exp_req = 1'b1; exp_valid = 1'b0;
    imem_ack = 1'b0;
    repeat (waits) go;
    imem_ack = 1'b1; imem_rdata = word;
    go;
    imem_ack = 1'b0; imem_rdata = 32'hDEAD_BEEF;
    m_instr = word; exp_req = 1'b0; exp_valid = 1'b1;
  endtask

  // Hold cycles drive stray ack/branch/jump that must have no effect without commit.
  task automatic exec(input logic br, input logic jmp, input logic z, input int holds);
    commit = 1'b0;
    repeat (holds) begin
      imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF; branch = 1'b1; jump = 1'b1;
      go;
    end
    imem_ack = 1'b0; branch = br; jump = jmp; zero = z; commit = 1'b1;
    go;
    commit = 1'b0; branch = 1'b0; jump = 1'b0;
    m_pc = model_next(m_pc, m_instr, br, jmp, z);
    exp_valid = 1'b0; exp_req = 1'b1;
  endtask

  task automatic timeout_fetch;
    exp_req = 1'b1; exp_valid = 1'b0; imem_ack = 1'b0;
    repeat (TIMEOUT) go;
    exp_req = 1'b0; exp_fault = 1'b1;
    chk("fault_set", {31'd0, fault}, 32'd1);
    chk("fault_req", {31'd0, imem_req}, 32'd0);
    repeat (3) begin
      imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
      go;
    end
    imem_ack = 1'b0;
    chk("fault_sticky", {31'd0, fault}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    go; go;
    check_en = 1'b1;
    apply_reset;

    fetch(32'h2008_0005, 0);
    chk("addi_opcode", {26'd0, opcode}, 32'h08);
    chk("addi_valid", {31'd0, instr_valid}, 32'd1);
    exec(1'b0, 1'b0, 1'b0, 2);
    chk("seq_pc", pc, 32'h4);
    chk("seq_req", {31'd0, imem_req}, 32'd1);

    fetch(32'h0000_0000, 3); exec(1'b0, 1'b0, 1'b0, 0);
    chk("seq_pc8", pc, 32'h8);
    fetch(32'h1000_0003, 0); exec(1'b1, 1'b0, 1'b1, 0);
    chk("beq_taken", pc, 32'h18);
    fetch(32'h0800_0002, 0); exec(1'b0, 1'b1, 1'b0, 0);
    chk("j_back8", pc, 32'h8);
    fetch(32'h1000_0003, 0); exec(1'b1, 1'b0, 1'b0, 0);
    chk("beq_not_taken", pc, 32'hC);
    fetch(32'h0800_0002, 0); exec(1'b0, 1'b1, 1'b0, 0);
    fetch(32'h1400_FFFF, 2); exec(1'b1, 1'b0, 1'b0, 1);
    chk("bne_back", pc, 32'h8);

    // Climb one PC region per step: jump to the region's last word, then fall through.
    for (int n = 0; n < 4; n++) begin
      fetch(32'h0BFF_FFFF, 0); exec(1'b0, 1'b1, 1'b0, 0);
      fetch(32'h0000_0000, 0); exec(1'b0, 1'b0, 1'b0, 0);
    end
    chk("region4", pc, 32'h4000_0000);
    fetch(32'h0800_0004, 0); exec(1'b0, 1'b1, 1'b0, 0);
    chk("pc_4000_0010", pc, 32'h4000_0010);
    fetch(32'h0800_0100, 0); exec(1'b1, 1'b1, 1'b1, 0);
    chk("jump_wins", pc, 32'h4000_0400);

    for (int n = 4; n < 16; n++) begin
      fetch(32'h0BFF_FFFF, 0); exec(1'b0, 1'b1, 1'b0, 0);
      if (n < 15) begin
        fetch(32'h0000_0000, 0); exec(1'b0, 1'b0, 1'b0, 0);
      end
    end
    chk("top_pc", pc, 32'hFFFF_FFFC);
    chk("top_plus4", pc_plus4, 32'h0);
    fetch(32'h0000_0020, 1); exec(1'b0, 1'b0, 1'b0, 0);
    chk("wrap_pc", pc, 32'h0);

    fetch(32'h2008_0005, 0);
    chk("pre_reset_valid", {31'd0, instr_valid}, 32'd1);
    apply_reset;

    timeout_fetch;
    apply_reset;
    fetch(32'h2008_0005, 0); exec(1'b0, 1'b0, 1'b0, 0);
    chk("post_fault_pc", pc, RESET_PC + 32'd4);

    check_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
